// File: rtl/gap_fill_pkg.sv
// gap_fill_pkg: shared types and sizing helpers for gap_fill_buffer.
// Entry values are stored at the widest supported sample width and truncated on read.
package gap_fill_pkg;

    localparam int MAX_W = 24;

    typedef enum logic [1:0] {
        FILL_IDLE,
        FILL_DIV,
        FILL_WRITE
    } fill_state_e;

    typedef struct packed {
        logic [MAX_W-1:0] value;
        logic             filled;
    } entry_t;

    function automatic int acc_w(input int width, input int max_gap);
        return width + $clog2(max_gap) + 2;
    endfunction

    function automatic int fill_cyc(input int width, input int max_gap);
        return width + $clog2(max_gap) + 4;
    endfunction

endpackage

// File: rtl/gap_fill_buffer_serial_sdiv.sv
// serial_sdiv: restoring signed divider, one quotient bit per clock, truncates toward zero.
// Magnitudes are divided unsigned and the sign is reapplied on the result.
module serial_sdiv #(
    parameter int NUM_W = 21,
    parameter int DEN_W = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic signed [NUM_W-1:0] num,
    input  logic signed [DEN_W-1:0] den,
    output logic                    done,
    output logic signed [NUM_W-1:0] quo
);

    localparam int CNT_W = $clog2(NUM_W + 1);

    logic [NUM_W-1:0] quo_q, quo_d;
    logic [DEN_W:0]   rem_q, rem_d, dmag_q, dmag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d, done_q, done_d;
    logic [DEN_W+1:0] sh;
    logic             ge;

    always_comb begin
        quo_d  = quo_q;
        rem_d  = rem_q;
        dmag_d = dmag_q;
        cnt_d  = cnt_q;
        neg_d  = neg_q;
        done_d = 1'b0;
        sh     = {rem_q, quo_q[NUM_W-1]};
        ge     = sh >= {1'b0, dmag_q};
        if (start) begin
            quo_d  = num[NUM_W-1] ? -num : num;
            dmag_d = den[DEN_W-1] ? -{den[DEN_W-1], den} : {den[DEN_W-1], den};
            rem_d  = '0;
            cnt_d  = CNT_W'(NUM_W);
            neg_d  = num[NUM_W-1] ^ den[DEN_W-1];
        end else if (cnt_q != '0) begin
            rem_d  = (DEN_W+1)'(ge ? sh - {1'b0, dmag_q} : sh);
            quo_d  = {quo_q[NUM_W-2:0], ge};
            cnt_d  = cnt_q - 1'b1;
            done_d = cnt_q == CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dmag_q <= '0;
            cnt_q  <= '0;
            neg_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dmag_q <= dmag_d;
            cnt_q  <= cnt_d;
            neg_q  <= neg_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign quo  = neg_q ? -$signed(quo_q) : $signed(quo_q);

endmodule

// File: rtl/gap_fill_buffer.sv
// gap_fill_buffer: DEPTH-slot delay line that repairs missing samples by hold or linear interpolation.
// Define GAP_FILL_STATS_EN to build the saturating fill_count statistic.
module gap_fill_buffer
    import gap_fill_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 8,
    parameter int MAX_GAP = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             slot_tick,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             valid_in,
    input  logic             mode_lin,
    input  logic             clr_err,
    output logic [WIDTH-1:0] sample_out,
    output logic             valid_out,
    output logic             filled_out,
    output logic             gap_err,
    output logic             busy_err,
    output logic [15:0]      fill_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int GL_W  = $clog2(MAX_GAP + 2);
    localparam int ACC_W = acc_w(WIDTH, MAX_GAP);
    localparam int DEN_W = GL_W + 1;

    entry_t mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic             primed_q, primed_d;
    logic [GL_W-1:0]  gap_len_q, gap_len_d;
    logic [WIDTH-1:0] last_valid_q, last_valid_d;
    logic             anchored_q, anchored_d;
    logic [WIDTH-1:0] sample_out_q, sample_out_d;
    logic             filled_out_q, filled_out_d;
    logic             valid_out_q, valid_out_d;
    logic             gap_err_q, gap_err_d;
    logic             busy_err_q, busy_err_d;

    fill_state_e             st_q, st_d;
    logic [GL_W-1:0]         k_q, k_d, idx_q, idx_d;
    logic [WIDTH-1:0]        last_q, last_d, val_q, val_d;
    logic signed [WIDTH:0]   diff_q, diff_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [PTR_W-1:0]        fptr_q, fptr_d;

    logic                    tick_valid, tick_miss, closing, start_fill;
    logic                    wr_en;
    logic [PTR_W-1:0]        wr_addr;
    entry_t                  wr_data;
    logic                    div_start, div_done;
    logic signed [DEN_W-1:0] div_den;
    logic signed [ACC_W-1:0] div_quo;

    always_comb begin
        tick_valid   = slot_tick & valid_in;
        tick_miss    = slot_tick & ~valid_in;
        closing      = tick_valid & (gap_len_q != '0);
        start_fill   = closing & mode_lin & anchored_q & (gap_len_q <= GL_W'(MAX_GAP)) & (st_q == FILL_IDLE);
        wr_ptr_d     = slot_tick ? wr_ptr_q + 1'b1 : wr_ptr_q;
        primed_d     = primed_q | (slot_tick & (wr_ptr_q == PTR_W'(DEPTH - 1)));
        gap_len_d    = tick_valid ? '0 : (tick_miss && gap_len_q != GL_W'(MAX_GAP + 1)) ? gap_len_q + 1'b1 : gap_len_q;
        last_valid_d = tick_valid ? sample_in : last_valid_q;
        anchored_d   = anchored_q | tick_valid;
        valid_out_d  = slot_tick & primed_q;
        // Output registers stay at their reset value until the line is primed.
        sample_out_d = valid_out_d ? WIDTH'(mem_q[wr_ptr_q].value) : sample_out_q;
        filled_out_d = valid_out_d ? mem_q[wr_ptr_q].filled : filled_out_q;
        gap_err_d    = (gap_err_q & ~clr_err) | (closing & (gap_len_q > GL_W'(MAX_GAP)));
        busy_err_d   = (busy_err_q & ~clr_err) | (slot_tick & (st_q != FILL_IDLE));
        wr_en        = slot_tick | (st_q == FILL_WRITE);
        wr_addr      = slot_tick ? wr_ptr_q : fptr_q;
        wr_data      = slot_tick ? entry_t'{MAX_W'($signed(valid_in ? sample_in : last_valid_q)), ~valid_in}
                                 : entry_t'{MAX_W'($signed(val_q)), 1'b1};
    end

    always_comb begin
        st_d      = st_q;
        k_d       = k_q;
        idx_d     = idx_q;
        last_d    = last_q;
        val_d     = val_q;
        diff_d    = diff_q;
        acc_d     = acc_q;
        fptr_d    = fptr_q;
        div_start = 1'b0;
        unique case (st_q)
            FILL_IDLE: if (start_fill) begin
                k_d       = gap_len_q;
                idx_d     = GL_W'(1);
                last_d    = last_valid_q;
                diff_d    = $signed({sample_in[WIDTH-1], sample_in}) - $signed({last_valid_q[WIDTH-1], last_valid_q});
                acc_d     = ACC_W'(diff_d);
                fptr_d    = wr_ptr_q - PTR_W'(gap_len_q);
                div_start = 1'b1;
                st_d      = FILL_DIV;
            end
            FILL_DIV: if (div_done) begin
                val_d = WIDTH'(ACC_W'($signed(last_q)) + div_quo);
                st_d  = FILL_WRITE;
            end
            // A same-cycle slot_tick owns the write port; the engine retries next cycle.
            FILL_WRITE: if (!slot_tick) begin
                if (idx_q == k_q) begin
                    st_d = FILL_IDLE;
                end else begin
                    idx_d     = idx_q + 1'b1;
                    fptr_d    = fptr_q + 1'b1;
                    acc_d     = acc_q + ACC_W'(diff_q);
                    div_start = 1'b1;
                    st_d      = FILL_DIV;
                end
            end
            default: st_d = FILL_IDLE;
        endcase
        div_den = {1'b0, GL_W'(k_d + 1'b1)};
    end

    serial_sdiv #(
        .NUM_W(ACC_W),
        .DEN_W(DEN_W)
    ) u_div (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (div_start),
        .num    (acc_d),
        .den    (div_den),
        .done   (div_done),
        .quo    (div_quo)
    );

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            primed_q     <= 1'b0;
            gap_len_q    <= '0;
            last_valid_q <= '0;
            anchored_q   <= 1'b0;
            sample_out_q <= '0;
            filled_out_q <= 1'b0;
            valid_out_q  <= 1'b0;
            gap_err_q    <= 1'b0;
            busy_err_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            primed_q     <= primed_d;
            gap_len_q    <= gap_len_d;
            last_valid_q <= last_valid_d;
            anchored_q   <= anchored_d;
            sample_out_q <= sample_out_d;
            filled_out_q <= filled_out_d;
            valid_out_q  <= valid_out_d;
            gap_err_q    <= gap_err_d;
            busy_err_q   <= busy_err_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q   <= FILL_IDLE;
            k_q    <= '0;
            idx_q  <= '0;
            last_q <= '0;
            val_q  <= '0;
            diff_q <= '0;
            acc_q  <= '0;
            fptr_q <= '0;
        end else begin
            st_q   <= st_d;
            k_q    <= k_d;
            idx_q  <= idx_d;
            last_q <= last_d;
            val_q  <= val_d;
            diff_q <= diff_d;
            acc_q  <= acc_d;
            fptr_q <= fptr_d;
        end
    end

`ifdef GAP_FILL_STATS_EN
    logic [15:0] fill_count_q, fill_count_d;

    always_comb begin
        fill_count_d = (valid_out_q && filled_out_q && fill_count_q != 16'hFFFF) ? fill_count_q + 16'd1 : fill_count_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) fill_count_q <= '0;
        else          fill_count_q <= fill_count_d;
    end

    assign fill_count = fill_count_q;
`else
    assign fill_count = '0;
`endif

    assign sample_out = sample_out_q;
    assign valid_out  = valid_out_q;
    assign filled_out = filled_out_q;
    assign gap_err    = gap_err_q;
    assign busy_err   = busy_err_q;

endmodule

// File: tb/tb_gap_fill_buffer.sv
// tb_gap_fill_buffer: directed and random slot streams checked against a tick-indexed history model.
module tb_gap_fill_buffer;
    import gap_fill_pkg::*;

    localparam int W       = 16;
    localparam int DEPTH   = 8;
    localparam int MAX_GAP = 6;
    localparam int SPACE   = MAX_GAP * fill_cyc(W, MAX_GAP) + 8;
`ifdef GAP_FILL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk = 1'b0, reset_n = 1'b0, slot_tick = 1'b0, valid_in = 1'b0, mode_lin = 1'b0, clr_err = 1'b0;
    logic [W-1:0] sample_in = '0;
    logic [W-1:0] sample_out;
    logic         valid_out, filled_out, gap_err, busy_err;
    logic [15:0]  fill_count;

    int n_tests = 0, n_fail = 0;

    int hv[$];
    bit hf[$];
    int m_last, m_gap, m_n, m_cnt;
    bit m_anch, m_gerr;

    logic signed [31:0] got_s;
    logic               got_v, got_f;

    gap_fill_buffer #(.WIDTH(W), .DEPTH(DEPTH), .MAX_GAP(MAX_GAP)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .slot_tick (slot_tick),
        .sample_in (sample_in),
        .valid_in  (valid_in),
        .mode_lin  (mode_lin),
        .clr_err   (clr_err),
        .sample_out(sample_out),
        .valid_out (valid_out),
        .filled_out(filled_out),
        .gap_err   (gap_err),
        .busy_err  (busy_err),
        .fill_count(fill_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        hv.delete();
        hf.delete();
        m_last = 0;
        m_gap  = 0;
        m_n    = 0;
        m_cnt  = 0;
        m_anch = 1'b0;
        m_gerr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sample", $signed(sample_out), 0);
        check("rst_valid", valid_out, 0);
        check("rst_filled", filled_out, 0);
        check("rst_errs", {gap_err, busy_err}, 0);
        check("rst_count", fill_count, 0);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic tick(input logic v, input int s, input logic m, input int gapc);
        @(negedge clk);
        slot_tick = 1'b1;
        valid_in  = v;
        sample_in = s[W-1:0];
        mode_lin  = m;
        @(negedge clk);
        slot_tick = 1'b0;
        valid_in  = 1'b0;
        got_v = valid_out;
        got_s = $signed(sample_out);
        got_f = filled_out;
        repeat (gapc - 1) @(negedge clk);
    endtask

    task automatic mtick(input logic v, input int s, input logic m, input int gapc);
        tick(v, s, m, gapc);
        check("valid_out", got_v, m_n >= DEPTH);
        if (m_n >= DEPTH) begin
            check("sample_out", got_s, hv[m_n-DEPTH]);
            check("filled_out", got_f, hf[m_n-DEPTH]);
            if (hf[m_n-DEPTH] && m_cnt < 65535) m_cnt++;
        end
        if (v) begin
            if (m_gap > MAX_GAP) m_gerr = 1'b1;
            else if (m_gap > 0 && m && m_anch)
                for (int i = 1; i <= m_gap; i++)
                    hv[m_n-m_gap+i-1] = m_last + ((s - m_last) * i) / (m_gap + 1);
            m_gap  = 0;
            m_last = s;
            m_anch = 1'b1;
            hv.push_back(s);
            hf.push_back(1'b0);
        end else begin
            hv.push_back(m_last);
            hf.push_back(1'b1);
            if (m_gap <= MAX_GAP) m_gap++;
        end
        m_n++;
        check("gap_err", gap_err, m_gerr);
        check("busy_err", busy_err, 0);
        check("fill_count", fill_count, STATS ? m_cnt : 0);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        m_gerr  = 1'b0;
    endtask

    initial begin
        int bs[5];
        bit bv[5], bf[5];
        do_reset();
        // interpolation, hold, negative-slope truncation, over-long gap
        mtick(1, 100, 1, SPACE);
        repeat (3) mtick(0, 0, 1, SPACE);
        mtick(1, 500, 1, SPACE);
        mtick(1, 100, 0, SPACE);
        repeat (3) mtick(0, 0, 0, SPACE);
        mtick(1, 500, 0, SPACE);
        mtick(1, 10, 1, SPACE);
        repeat (2) mtick(0, 0, 1, SPACE);
        mtick(1, 0, 1, SPACE);
        mtick(1, 100, 1, SPACE);
        repeat (7) mtick(0, 0, 1, SPACE);
        mtick(1, 900, 1, SPACE);
        check("gap_err_set", gap_err, 1);
        for (int i = 0; i < DEPTH; i++) mtick(1, -i * 1000, 1, SPACE);
        pulse_clr();
        check("gap_err_clr", gap_err, 0);

        do_reset();
        mtick(0, 0, 1, SPACE);
        mtick(0, 0, 1, SPACE);
        mtick(1, 50, 1, SPACE);
        for (int i = 0; i < DEPTH; i++) mtick(1, 60 + i, 1, SPACE);
        check("lead_fill_count", fill_count, STATS ? 2 : 0);

        // ticks every 10 clk while a 3-slot fill is running
        do_reset();
        for (int k = 0; k < 13; k++) begin
            tick(k == 0 || k >= 4, k == 0 ? 100 : k == 4 ? 500 : 0, 1, 10);
            if (k >= 8) begin
                bv[k-8] = got_v;
                bs[k-8] = got_s;
                bf[k-8] = got_f;
            end
        end
        check("busy_err_set", busy_err, 1);
        for (int j = 0; j < 5; j++) check("busy_valid", bv[j], 1);
        check("busy_anchor0", bs[0], 100);
        check("busy_anchor0_f", bf[0], 0);
        check("busy_anchor1", bs[4], 500);
        check("busy_anchor1_f", bf[4], 0);
        for (int j = 1; j < 4; j++) begin
            check("busy_fill_f", bf[j], 1);
            check("busy_fill_hold_or_interp", bs[j] == 100 || bs[j] == 100 + 100 * j, 1);
        end
        repeat (200) @(negedge clk);
        pulse_clr();
        check("busy_err_clr", busy_err, 0);

        // reset while the engine is mid-fill
        do_reset();
        mtick(1, 77, 1, SPACE);
        repeat (7) mtick(0, 0, 1, SPACE);
        mtick(1, 100, 1, SPACE);
        repeat (2) mtick(0, 0, 1, SPACE);
        mtick(1, 500, 1, 3);
        check("pre_rst_filled", filled_out, 1);
        repeat (4) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_sample", $signed(sample_out), 0);
        check("midrst_valid", valid_out, 0);
        check("midrst_filled", filled_out, 0);
        check("midrst_gap_err", gap_err, 0);
        check("midrst_busy_err", busy_err, 0);
        check("midrst_count", fill_count, 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < DEPTH + 1; i++) mtick(1, 200 + i, 1, SPACE);

        for (int i = 0; i < 100; i++) begin
            mtick($urandom_range(0, 9) < 6, int'($urandom_range(0, 65535)) - 32768, 1'($urandom_range(0, 1)), SPACE);
            if ($urandom_range(0, 15) == 0) begin
                pulse_clr();
                check("rand_clr", gap_err, m_gerr);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
